// File: rtl/dcache_refill_pkg.sv
// dcache_refill_pkg
//   Shared definitions for the data-cache refill sequencer:
//   - default configuration of the cache geometry (CFG_*)
//   - derived address-field widths (WSEL_BITS, OFFSET_BITS, TAG_BITS)
//   - refill FSM state enum
//   - helpers that split a byte address into index / tag / line base
//   The address layout is: [tag | index | word-in-line | byte-in-word].
package dcache_refill_pkg;

  localparam int CFG_NTHREADS       = 4;
  localparam int CFG_WORDS_PER_LINE = 4;
  localparam int CFG_INDEX_BITS     = 7;
  localparam int CFG_ADDR_WIDTH     = 32;
  localparam int CFG_DATA_WIDTH     = 32;

  // Word select within a line, then two byte-offset bits inside a 32-bit word.
  localparam int WSEL_BITS   = $clog2(CFG_WORDS_PER_LINE);
  localparam int OFFSET_BITS = WSEL_BITS + 2;
  localparam int TAG_BITS    = CFG_ADDR_WIDTH - CFG_INDEX_BITS - OFFSET_BITS;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FILL,
    COMMIT,
    DONE
  } state_t;

  function automatic logic [CFG_INDEX_BITS-1:0] get_index(input logic [CFG_ADDR_WIDTH-1:0] addr);
    return addr[OFFSET_BITS +: CFG_INDEX_BITS];
  endfunction

  function automatic logic [TAG_BITS-1:0] get_tag(input logic [CFG_ADDR_WIDTH-1:0] addr);
    return addr[CFG_ADDR_WIDTH-1 -: TAG_BITS];
  endfunction

  // Line-aligned byte address: offset bits forced to zero.
  function automatic logic [CFG_ADDR_WIDTH-1:0] line_base(input logic [CFG_ADDR_WIDTH-1:0] addr);
    return {addr[CFG_ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_refill_ctrl_rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin picker. Searches the request vector
//   starting at the thread after last_grant, wrapping around, and returns
//   the first requester.
//   Ports:
//     req         in  N    request vector
//     last_grant  in  IDW  thread that was granted most recently
//     grant       out N    one-hot grant (all zero when no request)
//     grant_id    out IDW  encoded grant
//     grant_valid out 1    at least one request present
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last_grant,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           grant_valid
);

  always_comb begin
    int             sum;
    logic [IDW-1:0] idx;
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    sum         = 0;
    idx         = '0;
    // k = N revisits last_grant itself, so a lone requester that was just
    // served can still be granted again.
    for (int k = 1; k <= N; k++) begin
      sum = int'(last_grant) + k;
      if (sum >= N) sum = sum - N;
      idx = IDW'(sum);
      if (!grant_valid && req[idx]) begin
        grant[idx]  = 1'b1;
        grant_id    = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcache_refill_ctrl.sv
// dcache_refill_ctrl
//   Data-cache miss/refill sequencer. Picks one missing thread round-robin,
//   issues a line read to memory, streams the returned words into the data
//   RAM, then commits tag + valid bit and pulses MissDone to the thread.
//   One refill is in flight at a time.
//   Ports:
//     clk, Reset                 clock / async active-high reset
//     MissReq, MissAddr          per-thread miss request (level) and byte address
//     MissDone                   one-cycle completion pulse, one-hot by thread
//     MemReq, MemAddr, MemAck    line read request handshake
//     MemRdValid, MemRdData      returned data words
//     DataWrite, DataIndex,
//     DataWordSel, DataWdata     data RAM write port
//     TagWrite, TagData          tag RAM write port
//     WriteValid, CacheIndexWrite valid-bit set port (index shared with tag RAM)
//     Busy                       refill in progress
module dcache_refill_ctrl
  import dcache_refill_pkg::*;
#(
  parameter int NTHREADS       = CFG_NTHREADS,
  parameter int WORDS_PER_LINE = CFG_WORDS_PER_LINE,
  parameter int INDEX_BITS     = CFG_INDEX_BITS,
  parameter int ADDR_WIDTH     = CFG_ADDR_WIDTH,
  parameter int DATA_WIDTH     = CFG_DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic [NTHREADS-1:0]        MissReq,
  input  logic [NTHREADS*ADDR_WIDTH-1:0] MissAddr,
  output logic [NTHREADS-1:0]        MissDone,
  output logic                       MemReq,
  output logic [ADDR_WIDTH-1:0]      MemAddr,
  input  logic                       MemAck,
  input  logic                       MemRdValid,
  input  logic [DATA_WIDTH-1:0]      MemRdData,
  output logic                       DataWrite,
  output logic [INDEX_BITS-1:0]      DataIndex,
  output logic [WSEL_BITS-1:0]       DataWordSel,
  output logic [DATA_WIDTH-1:0]      DataWdata,
  output logic                       TagWrite,
  output logic [TAG_BITS-1:0]        TagData,
  output logic                       WriteValid,
  output logic [INDEX_BITS-1:0]      CacheIndexWrite,
  output logic                       Busy
);

  localparam int IDW = (NTHREADS > 1) ? $clog2(NTHREADS) : 1;
  localparam logic [WSEL_BITS-1:0] LAST_WORD = WSEL_BITS'(WORDS_PER_LINE - 1);

  state_t                  state_reg;
  logic [IDW-1:0]          thread_id_reg;
  logic [NTHREADS-1:0]     thread_onehot_reg;
  logic [IDW-1:0]          last_grant_reg;
  logic [INDEX_BITS-1:0]   index_reg;
  logic [TAG_BITS-1:0]     tag_reg;
  logic [ADDR_WIDTH-1:0]   base_reg;
  logic [WSEL_BITS-1:0]    word_cnt_reg;
  logic                    mem_req_reg;
  logic                    tag_write_reg;
  logic                    write_valid_reg;
  logic [NTHREADS-1:0]     miss_done_reg;

  logic [NTHREADS-1:0]     grant;
  logic [IDW-1:0]          grant_id;
  logic                    grant_valid;
  logic [ADDR_WIDTH-1:0]   miss_addr_arr [NTHREADS];
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic                    data_write;

  generate
    for (genvar gi = 0; gi < NTHREADS; gi++) begin : g_addr
      assign miss_addr_arr[gi] = MissAddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    end
  endgenerate

  rr_arbiter #(
    .N   (NTHREADS),
    .IDW (IDW)
  ) u_arb (
    .req         (MissReq),
    .last_grant  (last_grant_reg),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  assign sel_addr = miss_addr_arr[grant_id];

  // The data RAM strobe follows MemRdValid directly so each word is written
  // in the cycle it arrives; anything outside FILL is ignored.
  assign data_write = (state_reg == FILL) && MemRdValid;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_reg         <= IDLE;
      thread_id_reg     <= '0;
      thread_onehot_reg <= '0;
      last_grant_reg    <= IDW'(NTHREADS - 1);
      index_reg         <= '0;
      tag_reg           <= '0;
      base_reg          <= '0;
      word_cnt_reg      <= '0;
      mem_req_reg       <= 1'b0;
      tag_write_reg     <= 1'b0;
      write_valid_reg   <= 1'b0;
      miss_done_reg     <= '0;
    end else begin
      // Single-cycle strobes fall back to zero unless re-armed below.
      tag_write_reg   <= 1'b0;
      write_valid_reg <= 1'b0;
      miss_done_reg   <= '0;
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            thread_id_reg     <= grant_id;
            thread_onehot_reg <= grant;
            index_reg         <= get_index(sel_addr);
            tag_reg           <= get_tag(sel_addr);
            base_reg          <= line_base(sel_addr);
            mem_req_reg       <= 1'b1;
            state_reg         <= REQ;
          end
        end
        REQ: begin
          if (MemAck) begin
            mem_req_reg  <= 1'b0;
            word_cnt_reg <= '0;
            state_reg    <= FILL;
          end
        end
        FILL: begin
          if (MemRdValid) begin
            word_cnt_reg <= word_cnt_reg + 1'b1;
            if (word_cnt_reg == LAST_WORD) begin
              tag_write_reg   <= 1'b1;
              write_valid_reg <= 1'b1;
              state_reg       <= COMMIT;
            end
          end
        end
        COMMIT: begin
          miss_done_reg <= thread_onehot_reg;
          state_reg     <= DONE;
        end
        DONE: begin
          last_grant_reg <= thread_id_reg;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign MissDone        = miss_done_reg;
  assign MemReq          = mem_req_reg;
  assign MemAddr         = base_reg;
  assign DataWrite       = data_write;
  assign DataIndex       = index_reg;
  assign DataWordSel     = word_cnt_reg;
  assign DataWdata       = data_write ? MemRdData : '0;
  assign TagWrite        = tag_write_reg;
  assign TagData         = tag_reg;
  assign WriteValid      = write_valid_reg;
  assign CacheIndexWrite = index_reg;
  assign Busy            = (state_reg != IDLE);

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Self-checking bench for dcache_refill_ctrl: directed scenarios plus a
// randomized multi-thread phase, checked against an arithmetic model of the
// address split, round-robin order and refill timing.
module tb_dcache_refill_ctrl;
  import dcache_refill_pkg::*;

  localparam int NT = 4;
  localparam int W  = 4;
  localparam int IB = 7;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [AW-1:0] LINE_BYTES = 32'(W * 4);
  localparam logic [AW-1:0] NUM_LINES  = 32'(1 << IB);

  logic                clk = 1'b0;
  logic                Reset;
  logic [NT-1:0]       MissReq;
  logic [NT*AW-1:0]    MissAddr;
  logic [NT-1:0]       MissDone;
  logic                MemReq;
  logic [AW-1:0]       MemAddr;
  logic                MemAck;
  logic                MemRdValid;
  logic [DW-1:0]       MemRdData;
  logic                DataWrite;
  logic [IB-1:0]       DataIndex;
  logic [WSEL_BITS-1:0] DataWordSel;
  logic [DW-1:0]       DataWdata;
  logic                TagWrite;
  logic [TAG_BITS-1:0] TagData;
  logic                WriteValid;
  logic [IB-1:0]       CacheIndexWrite;
  logic                Busy;

  always #5 clk = ~clk;

  dcache_refill_ctrl dut (
    .clk             (clk),
    .Reset           (Reset),
    .MissReq         (MissReq),
    .MissAddr        (MissAddr),
    .MissDone        (MissDone),
    .MemReq          (MemReq),
    .MemAddr         (MemAddr),
    .MemAck          (MemAck),
    .MemRdValid      (MemRdValid),
    .MemRdData       (MemRdData),
    .DataWrite       (DataWrite),
    .DataIndex       (DataIndex),
    .DataWordSel     (DataWordSel),
    .DataWdata       (DataWdata),
    .TagWrite        (TagWrite),
    .TagData         (TagData),
    .WriteValid      (WriteValid),
    .CacheIndexWrite (CacheIndexWrite),
    .Busy            (Busy)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int wv_seen  = 0;
  int refills_done = 0;
  int model_last = NT - 1;
  logic [AW-1:0] miss_addr_m [NT];

  always @(negedge clk) if (WriteValid === 1'b1) wv_seen <= wv_seen + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference address split from plain arithmetic on the byte address.
  function automatic logic [AW-1:0] exp_base(input logic [AW-1:0] a);
    return (a / LINE_BYTES) * LINE_BYTES;
  endfunction

  function automatic logic [IB-1:0] exp_index(input logic [AW-1:0] a);
    logic [AW-1:0] q;
    q = (a / LINE_BYTES) % NUM_LINES;
    return q[IB-1:0];
  endfunction

  function automatic logic [TAG_BITS-1:0] exp_tag(input logic [AW-1:0] a);
    logic [AW-1:0] q;
    q = a / (LINE_BYTES * NUM_LINES);
    return q[TAG_BITS-1:0];
  endfunction

  // Fairness rule: first requester after the last served thread, wrapping.
  function automatic int pick_thread(input logic [NT-1:0] req, input int last);
    for (int k = 1; k <= NT; k++) begin
      if (req[(last + k) % NT]) return (last + k) % NT;
    end
    return -1;
  endfunction

  task automatic set_addr(input int t, input logic [AW-1:0] a);
    MissAddr[t*AW +: AW] = a;
    miss_addr_m[t] = a;
  endtask

  task automatic quiet(input string tag);
    chk({tag, "_strb"}, {MemReq, DataWrite, TagWrite, WriteValid, MissDone, Busy}, 64'd0);
    chk({tag, "_bus1"}, {MemAddr, DataWdata}, 64'd0);
    chk({tag, "_bus2"}, {DataIndex, DataWordSel, TagData, CacheIndexWrite}, 64'd0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    MissReq = '0;
    MemAck = 1'b0;
    MemRdValid = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    model_last = NT - 1;
    tick();
  endtask

  // Runs one refill for thread thr. Returns the cycle count from call to MissDone.
  task automatic service(input int thr, input int ack_dly, input int gap, input bit spur,
                         input bit withdraw, input bit keep, input int abort_after,
                         output int lat);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit got;
    int waited;
    a = miss_addr_m[thr];
    lat = 0;
    got = 1'b0;
    waited = 0;
    while (!got && waited < 40) begin
      tick();
      lat++;
      waited++;
      if (MemReq === 1'b1) got = 1'b1;
    end
    chk("memreq_seen", 64'(got), 64'd1);
    if (!got) return;
    chk("memaddr", MemAddr, exp_base(a));
    chk("busy_req", Busy, 1);
    for (int i = 0; i < ack_dly; i++) begin
      MemRdValid = spur;
      #1;
      chk("req_nowrite", {DataWrite, TagWrite, WriteValid}, 64'd0);
      tick();
      lat++;
      chk("memreq_hold", {MemReq, MemAddr}, {1'b1, exp_base(a)});
    end
    MemRdValid = 1'b0;
    MemAck = 1'b1;
    tick();
    lat++;
    MemAck = 1'b0;
    chk("memreq_drop", MemReq, 0);
    for (int w = 0; w < W; w++) begin
      for (int g = 0; g < gap; g++) begin
        MemRdValid = 1'b0;
        #1;
        chk("gap_nowrite", {DataWrite, TagWrite, WriteValid}, 64'd0);
        tick();
        lat++;
      end
      if (abort_after == w) begin
        MemRdValid = 1'b0;
        Reset = 1'b1;
        #1;
        quiet("reset_async");
        tick();
        quiet("reset_edge");
        MissReq = '0;
        Reset = 1'b0;
        model_last = NT - 1;
        tick();
        quiet("reset_release");
        $display("refill thread %0d aborted by reset after %0d words", thr, w);
        return;
      end
      d = $urandom;
      MemRdValid = 1'b1;
      MemRdData = d;
      #1;
      chk("dwrite", {DataWrite, DataIndex, DataWordSel, DataWdata},
          {1'b1, exp_index(a), 2'(w), d});
      chk("dwrite_excl", {TagWrite, WriteValid, MissDone}, 64'd0);
      tick();
      lat++;
      MemRdValid = 1'b0;
      if (withdraw && w == 1) MissReq[thr] = 1'b0;
    end
    #1;
    chk("commit", {TagWrite, WriteValid, CacheIndexWrite, TagData},
        {2'b11, exp_index(a), exp_tag(a)});
    chk("commit_excl", {DataWrite, MissDone}, 64'd0);
    tick();
    lat++;
    chk("done", MissDone, 64'(4'(1) << thr));
    chk("done_excl", {DataWrite, TagWrite, WriteValid}, 64'd0);
    if (!keep) MissReq[thr] = 1'b0;
    tick();
    chk("idle_after", {MissDone, Busy}, 64'd0);
    model_last = thr;
    refills_done++;
    $display("refill thread %0d addr 0x%08h index 0x%02h tag 0x%06h cycles %0d",
             thr, a, exp_index(a), exp_tag(a), lat);
  endtask

  initial begin
    int lat;
    int thr;
    logic [NT-1:0] req;
    int rr_order [5];

    Reset = 1'b1;
    MissReq = '0;
    MissAddr = '0;
    MemAck = 1'b0;
    MemRdValid = 1'b0;
    MemRdData = '0;
    for (int t = 0; t < NT; t++) miss_addr_m[t] = '0;
    #1;
    quiet("reset_init");
    tick();
    tick();
    Reset = 1'b0;
    tick();
    quiet("after_reset");

    // Single miss, minimum latency.
    set_addr(1, 32'h0000_1234);
    MissReq = 4'b0010;
    service(1, 0, 0, 1'b0, 1'b0, 1'b0, -1, lat);
    chk("single_latency", lat, 7);

    // Spurious MemRdValid / MemAck while IDLE.
    MemRdValid = 1'b1;
    MemAck = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("spur_idle", {DataWrite, MemReq, Busy, DataWordSel}, 64'd0);
    end
    MemRdValid = 1'b0;
    MemAck = 1'b0;

    // Stalled memory with spurious data in REQ and gaps between words.
    set_addr(3, $urandom);
    MissReq = 4'b1000;
    service(3, 5, 1, 1'b1, 1'b0, 1'b0, -1, lat);

    // Withdrawn request mid-fill.
    set_addr(2, $urandom);
    MissReq = 4'b0100;
    service(2, 1, 0, 1'b0, 1'b1, 1'b0, -1, lat);
    chk("withdraw_req_low", MissReq[2], 0);

    // Randomized contention; held requests keep their addresses.
    for (int it = 0; it < 8; it++) begin
      req = MissReq | 4'($urandom_range(1, 15));
      for (int t = 0; t < NT; t++)
        if (req[t] && !MissReq[t]) set_addr(t, $urandom);
      MissReq = req;
      thr = pick_thread(req, model_last);
      service(thr, $urandom_range(0, 3), $urandom_range(0, 1), 1'($urandom_range(0, 1)),
              1'b0, 1'b0, -1, lat);
    end
    MissReq = '0;
    tick();

    // Reset in the middle of a fill, then a clean refill for thread 0.
    set_addr(1, $urandom);
    MissReq = 4'b0010;
    service(1, 0, 0, 1'b0, 1'b0, 1'b0, 2, lat);
    tick();
    chk("abort_no_valid", wv_seen, refills_done);
    set_addr(0, $urandom);
    MissReq = 4'b0001;
    service(0, 0, 0, 1'b0, 1'b0, 1'b0, -1, lat);
    chk("post_abort_latency", lat, 7);

    // Round robin with all threads holding requests from reset.
    do_reset();
    quiet("rr_reset");
    for (int t = 0; t < NT; t++) set_addr(t, $urandom);
    rr_order[0] = 0; rr_order[1] = 1; rr_order[2] = 2; rr_order[3] = 3; rr_order[4] = 0;
    MissReq = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      service(rr_order[i], 0, 0, 1'b0, 1'b0, 1'b1, -1, lat);
    end
    MissReq = '0;
    tick();
    tick();
    chk("wv_total", wv_seen, refills_done);
    chk("final_idle", {Busy, MemReq}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
